fwd_scoreboard: RTL

Parametrised operand-forwarding unit for the execute stage. It replaces the fixed 2-source, 3-way forwarding mux with a self-tracking scoreboard.
- Holds a DEPTH-entry shift pipeline of in-flight results (rd, write-enable, load flag, data).
- Resolves NUM_SRC source operands against that pipeline, youngest match first.
- Raises a load-use stall when the matching producer's data is not yet available.
Sits between the ID/EX register and the ALU. Also owns the EX/MEM/WB destination bookkeeping for forwarding.

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_resolve.sv | 38 +++
 rtl/fwd_scoreboard.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding scoreboard and its per-operand resolver.
// Purely declarative: no logic, no latency, no flow control.
package fwd_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Result data travels in a parallel XLEN-wide array; the package cannot see XLEN.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } fwd_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_resolve.sv
// Priority match of one source operand against the in-flight result pipeline (youngest stage wins).
// Latency: purely combinational. Backpressure: none; raises hazard when the winning load is not yet loaded.
module fwd_resolve
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 1,
    parameter int SELW       = sel_width(DEPTH)
) (
    input  fwd_entry_t             entry      [DEPTH],
    input  logic [XLEN-1:0]        entry_data [DEPTH],
    input  logic [REG_ADDR_W-1:0]  src,
    input  logic [XLEN-1:0]        rf_data,
    output logic [XLEN-1:0]        fwd_data,
    output logic [SELW-1:0]        fwd_sel,
    output logic                   hazard
);

    always_comb begin
        fwd_data = rf_data;
        fwd_sel  = '0;
        hazard   = 1'b0;
        if (src == REG_ZERO) begin
            fwd_data = '0;
        end else begin
            // Walk oldest to youngest so the youngest match overwrites the rest.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (entry[k].valid && entry[k].we && (entry[k].rd == src)) begin
                    fwd_data = entry_data[k];
                    fwd_sel  = SELW'(k + 1);
                    hazard   = entry[k].is_load && (k < LOAD_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Execute-stage operand forwarding scoreboard; FWD_STATS_EN adds saturating forward/stall counters.
// Latency: zero-cycle operand resolution from registered state; results tracked for DEPTH post-EX stages.
// Backpressure: stall on load-use, inserting a bubble at stage 0 while older stages keep advancing.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int DEPTH      = 2,
    parameter  int NUM_SRC    = 2,
    parameter  int LOAD_STAGE = 1,
    localparam int SELW       = sel_width(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ex_valid,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_we,
    input  logic                          ex_is_load,
    input  logic [XLEN-1:0]               ex_result,
    input  logic [XLEN-1:0]               ld_data,
    input  logic                          flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]       rf_data,
    output logic [NUM_SRC*XLEN-1:0]       fwd_data,
    output logic [NUM_SRC*SELW-1:0]       fwd_sel,
    output logic                          stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                   stat_fwd_cnt,
    output logic [31:0]                   stat_stall_cnt
`endif
);

    fwd_entry_t        ent_q  [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [NUM_SRC-1:0] hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_resolve #(
            .XLEN       (XLEN),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SELW       (SELW)
        ) u_resolve (
            .entry      (ent_q),
            .entry_data (data_q),
            .src        (src_addr[REG_ADDR_W*i +: REG_ADDR_W]),
            .rf_data    (rf_data[XLEN*i +: XLEN]),
            .fwd_data   (fwd_data[XLEN*i +: XLEN]),
            .fwd_sel    (fwd_sel[SELW*i +: SELW]),
            .hazard     (hazard[i])
        );
    end

    assign stall = |hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_q[k] <= ent_q[k-1];
                if ((k == LOAD_STAGE) && ent_q[k-1].is_load) begin
                    data_q[k] <= ld_data;
                end else begin
                    data_q[k] <= data_q[k-1];
                end
            end
            if (stall) begin
                ent_q[0] <= '0;
            end else begin
                ent_q[0]  <= fwd_entry_t'{valid: ex_valid, rd: ex_rd, we: ex_we, is_load: ex_is_load};
                data_q[0] <= ((LOAD_STAGE == 0) && ex_is_load) ? ld_data : ex_result;
            end
            // Flush wins over both the shift and the new capture.
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    ent_q[k].valid <= 1'b0;
                end
            end
        end
    end

`ifdef FWD_STATS_EN
    localparam int INC_W = $clog2(NUM_SRC + 1);

    logic [INC_W-1:0] fwd_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [INC_W-1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    always_comb begin
        fwd_inc = '0;
        if (!stall) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fwd_sel[SELW*i +: SELW] != '0) begin
                    fwd_inc = fwd_inc + INC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fwd_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            stat_fwd_cnt   <= sat_add(stat_fwd_cnt, fwd_inc);
            stat_stall_cnt <= sat_add(stat_stall_cnt, INC_W'(stall));
        end
    end
`endif

endmodule
